// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: sequencing controller for a 5-stage MIPS-subset pipeline.
// Produces stall/flush/PC controls, EX operand forwarding selects, a
// RUN/DRAIN/HALTED halt sequencer and saturating performance counters.
// Control outputs are combinational from the registered state and the
// current pipeline inputs, so stalls and flushes act in the same cycle.
module pipe_hazard_ctrl #(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regw,
    input  logic             ex_memreg,
    input  logic             ex_br_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regw,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regw,
    input  logic             halt_req,
    input  logic             cnt_clr,
    output logic             pc_en,
    output logic             pc_sel_br,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    // Last drain count value before the sequencer enters HALTED.
    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYC - 1);

    state_t           state_q, state_d;
    logic [2:0]       drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             lu_hz_s;
    logic             stall_apply_s;
    logic             flush_apply_s;

    // Forwarding select for one EX source: the younger producer (EX/MEM) wins.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] m_rd,
        input logic       m_regw,
        input logic [4:0] w_rd,
        input logic       w_regw
    );
        if (m_regw && (m_rd != 5'd0) && (m_rd == src)) begin
            return 2'b10;
        end else if (w_regw && (w_rd != 5'd0) && (w_rd == src)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    always_comb begin
        lu_hz_s = ex_memreg && ex_regw && (ex_rd != 5'd0) &&
                  ((id_use_rs && (ex_rd == id_rs)) ||
                   (id_use_rt && (ex_rd == id_rt)));
    end

    // Next-state logic and pipeline controls for the halt sequencer.
    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        stall_apply_s = 1'b0;
        flush_apply_s = 1'b0;
        pc_en         = 1'b0;
        pc_sel_br     = 1'b0;
        ifid_en       = 1'b0;
        ifid_flush    = 1'b1;
        idex_flush    = 1'b1;
        halted        = 1'b0;
        fwd_a         = fwd_sel(ex_rs, mem_rd, mem_regw, wb_rd, wb_regw);
        fwd_b         = fwd_sel(ex_rt, mem_rd, mem_regw, wb_rd, wb_regw);

        case (state_q)
            ST_RUN: begin
                if (ex_br_taken) begin
                    // ID holds a wrong-path instruction, so the branch beats the stall.
                    pc_en         = 1'b1;
                    pc_sel_br     = 1'b1;
                    ifid_en       = 1'b1;
                    ifid_flush    = 1'b1;
                    idex_flush    = 1'b1;
                    flush_apply_s = 1'b1;
                end else if (lu_hz_s) begin
                    pc_en         = 1'b0;
                    ifid_en       = 1'b0;
                    ifid_flush    = 1'b0;
                    idex_flush    = 1'b1;
                    stall_apply_s = 1'b1;
                end else begin
                    pc_en         = 1'b1;
                    ifid_en       = 1'b1;
                    ifid_flush    = 1'b0;
                    idex_flush    = 1'b0;
                end
                if (halt_req && !lu_hz_s && !ex_br_taken) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 3'd0;
                end else begin
                    state_d     = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Fetch is suppressed while in-flight instructions complete.
                pc_en      = 1'b0;
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b0;
                if (ex_br_taken) begin
                    // Branch still redirects the PC so resume fetches the right target.
                    pc_en         = 1'b1;
                    pc_sel_br     = 1'b1;
                    idex_flush    = 1'b1;
                    flush_apply_s = 1'b1;
                end else if (lu_hz_s) begin
                    // Hold the stalled consumer in ID; the drain does not advance.
                    ifid_en       = 1'b0;
                    ifid_flush    = 1'b0;
                    idex_flush    = 1'b1;
                    stall_apply_s = 1'b1;
                end else begin
                    idex_flush    = 1'b0;
                end
                if (!stall_apply_s) begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d     = ST_HALTED;
                        drain_cnt_d = 3'd0;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 3'd1;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q;
                end
            end
            ST_HALTED: begin
                halted     = 1'b1;
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (!halt_req) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d     = ST_RUN;
                drain_cnt_d = 3'd0;
            end
        endcase

        // While reset is held the datapath sees a frozen, bubbled pipeline.
        if (!rst_n) begin
            pc_en         = 1'b0;
            pc_sel_br     = 1'b0;
            ifid_en       = 1'b0;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            halted        = 1'b0;
            fwd_a         = 2'b00;
            fwd_b         = 2'b00;
            stall_apply_s = 1'b0;
            flush_apply_s = 1'b0;
        end else begin
            stall_apply_s = stall_apply_s;
        end
    end

    // Next values of the saturating performance counters; clear has priority.
    always_comb begin
        cyc_cnt_d   = cyc_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            cyc_cnt_d   = {CNT_W{1'b0}};
            stall_cnt_d = {CNT_W{1'b0}};
            flush_cnt_d = {CNT_W{1'b0}};
        end else begin
            if (state_q != ST_HALTED) begin
                cyc_cnt_d = sat_inc(cyc_cnt_q);
            end else begin
                cyc_cnt_d = cyc_cnt_q;
            end
            if (stall_apply_s) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (flush_apply_s) begin
                flush_cnt_d = sat_inc(flush_cnt_q);
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end
    end

    // State, drain counter and performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= 3'd0;
            cyc_cnt_q   <= {CNT_W{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            cyc_cnt_q   <= cyc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Counter values are presented straight from their registers.
    always_comb begin
        cyc_cnt   = cyc_cnt_q;
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
    end

endmodule
